// File: rtl/orion_rst_seq.sv
// Reset sequencer downstream of the PLL: pulses pll_rst, qualifies a synchronised
// lock flag over a stability window, then releases sys_rst. Retries the PLL on lock timeout.
module orion_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2,
  localparam int RW            = $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          sys_ready,
  output logic          pll_fail,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state_o
);

  localparam int CNT_SPAN_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_SPAN    = (CNT_SPAN_AB > STABLE_CYCLES) ? CNT_SPAN_AB : STABLE_CYCLES;
  localparam int CNT_W       = $clog2(CNT_SPAN);

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 locked_s;
  logic [RW-1:0]        retry_nxt;
  logic                 pll_rst_nxt, sys_rst_nxt, sys_ready_nxt, pll_fail_nxt;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign state_o  = state;

  // State register, shared counter, lock synchroniser and registered outputs.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= S_PLLRST;
      cnt       <= '0;
      sync_q    <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      sys_ready <= 1'b0;
      pll_fail  <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= next_state;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      retry_cnt <= retry_nxt;
      pll_rst   <= pll_rst_nxt;
      sys_rst   <= sys_rst_nxt;
      sys_ready <= sys_ready_nxt;
      pll_fail  <= pll_fail_nxt;
      // Counter restarts on every transition and saturates while parked in RUN or FAIL.
      if (next_state != state) cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    next_state = state;
    retry_nxt  = retry_cnt;
    case (state)
      S_PLLRST: if (cnt == PLL_LAST) next_state = S_WAIT;
      S_WAIT: begin
        if (locked_s) begin
          next_state = S_STABLE;
        end else if (cnt == LOCK_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            next_state = S_FAIL;
          end else begin
            next_state = S_PLLRST;
            retry_nxt  = retry_cnt + 1'b1;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s)                next_state = S_WAIT;
        else if (cnt == STABLE_LAST)  next_state = S_RUN;
      end
      S_RUN:    if (!locked_s) next_state = S_WAIT;
      S_FAIL:   next_state = S_FAIL;
      default:  next_state = S_PLLRST;
    endcase
    if (next_state == S_RUN && state != S_RUN) retry_nxt = '0;
  end

  // Output decode from the upcoming state, so outputs change on the same edge as state.
  always_comb begin
    pll_rst_nxt   = (next_state == S_PLLRST) || (next_state == S_FAIL);
    sys_rst_nxt   = (next_state != S_RUN);
    sys_ready_nxt = (next_state == S_RUN);
    pll_fail_nxt  = (next_state == S_FAIL);
  end

endmodule
